// File: rtl/alu_op_issue_if.sv
// Valid/ready bundle between IF/ID, the ALU issue stage and EX.
// The master drives the upstream word, flush and the EX ready; the slave drives the rest.
interface alu_op_issue_if;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_func;
    logic [4:0]  out_shift;
    logic [4:0]  out_rs;
    logic [4:0]  out_rt;
    logic [4:0]  out_rd;
    logic [31:0] out_imm;
    logic        out_use_imm;
    logic        out_reg_write;
    logic        out_mem_read;
    logic        out_mem_write;
    logic        out_branch;
    logic        out_illegal;

    modport master (
        output in_valid, in_instr, flush, out_ready,
        input  in_ready, out_valid, out_func, out_shift, out_rs, out_rt,
        input  out_rd, out_imm, out_use_imm, out_reg_write,
        input  out_mem_read, out_mem_write, out_branch, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, flush, out_ready,
        output in_ready, out_valid, out_func, out_shift, out_rs, out_rt,
        output out_rd, out_imm, out_use_imm, out_reg_write,
        output out_mem_read, out_mem_write, out_branch, out_illegal
    );
endinterface

// File: rtl/alu_op_issue.sv
// ALU-op decode stage: MIPS word -> func/shift/operand controls,
// queued in a 2-entry skid buffer toward EX.
module alu_op_issue #(
    parameter int          DEPTH     = 2,
    parameter logic [4:0]  LUI_SHAMT = 5'd16
) (
    input logic          clk,
    input logic          rst,
    alu_op_issue_if.slave bus
);
    if (DEPTH != 2) begin : g_depth_chk
        $error("alu_op_issue: DEPTH must be 2");
    end

    localparam logic [1:0] F_SLL = 2'b00;
    localparam logic [1:0] F_ADD = 2'b01;
    localparam logic [1:0] F_SUB = 2'b10;
    localparam logic [1:0] F_OR  = 2'b11;

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    typedef struct packed {
        logic [1:0]  func;
        logic [4:0]  shift;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        use_imm;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        illegal;
    } ent_t;

    logic [5:0] op;
    logic [5:0] fn;
    logic       r_type;
    ent_t       dec;

    assign op     = bus.in_instr[31:26];
    assign fn     = bus.in_instr[5:0];
    assign r_type = (op == 6'h00);

    always_comb begin
        dec      = '0;
        dec.rs   = bus.in_instr[25:21];
        dec.rt   = bus.in_instr[20:16];
        dec.rd   = r_type ? bus.in_instr[15:11] : bus.in_instr[20:16];
        dec.imm  = {{16{bus.in_instr[15]}}, bus.in_instr[15:0]};
        dec.func = F_ADD;
        unique case (1'b1)
            r_type && (fn == 6'h20 || fn == 6'h21): begin
                dec.reg_write = 1'b1;
            end
            r_type && (fn == 6'h22 || fn == 6'h23): begin
                dec.func      = F_SUB;
                dec.reg_write = 1'b1;
            end
            r_type && (fn == 6'h25): begin
                dec.func      = F_OR;
                dec.reg_write = 1'b1;
            end
            r_type && (fn == 6'h00): begin
                dec.func      = F_SLL;
                dec.shift     = bus.in_instr[10:6];
                dec.reg_write = 1'b1;
            end
            (op == 6'h08 || op == 6'h09): begin
                dec.use_imm   = 1'b1;
                dec.reg_write = 1'b1;
            end
            (op == 6'h0D): begin
                dec.func      = F_OR;
                dec.imm       = {16'h0, bus.in_instr[15:0]};
                dec.use_imm   = 1'b1;
                dec.reg_write = 1'b1;
            end
            (op == 6'h23): begin
                dec.use_imm   = 1'b1;
                dec.mem_read  = 1'b1;
                dec.reg_write = 1'b1;
            end
            (op == 6'h2B): begin
                dec.use_imm   = 1'b1;
                dec.mem_write = 1'b1;
            end
            (op == 6'h04): begin
                dec.func   = F_SUB;
                dec.branch = 1'b1;
            end
            // lui: the immediate is Src1 and is shifted up by LUI_SHAMT
            (op == 6'h0F): begin
                dec.func      = F_SLL;
                dec.shift     = LUI_SHAMT;
                dec.imm       = {16'h0, bus.in_instr[15:0]};
                dec.use_imm   = 1'b1;
                dec.reg_write = 1'b1;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
    end

    logic [1:0] state;
    logic [1:0] nxt;
    logic       rdy;
    logic       push;
    logic       pop;
    ent_t       head;
    ent_t       tail;

    assign push = bus.in_valid & rdy & ~bus.flush;
    assign pop  = (state != S_EMPTY) & bus.out_ready;

    always_comb begin
        nxt = state;
        if (bus.flush) begin
            nxt = S_EMPTY;
        end else begin
            unique case (state)
                S_EMPTY: if (push) nxt = S_ONE;
                S_ONE: begin
                    if (push && !pop)      nxt = S_FULL;
                    else if (!push && pop) nxt = S_EMPTY;
                end
                S_FULL:  if (pop) nxt = S_ONE;
                default: nxt = S_EMPTY;
            endcase
        end
    end

    // head is always slot 0; tail only ever holds the second-oldest entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_EMPTY;
            rdy   <= 1'b1;
            head  <= '0;
            tail  <= '0;
        end else begin
            state <= nxt;
            rdy   <= (nxt != S_FULL);
            if (!bus.flush) begin
                if (state == S_FULL && pop)
                    head <= tail;
                else if (push && (state == S_EMPTY || pop))
                    head <= dec;
                if (push && state == S_ONE && !pop)
                    tail <= dec;
            end
        end
    end

    assign bus.in_ready      = rdy;
    assign bus.out_valid     = (state != S_EMPTY);
    assign bus.out_func      = head.func;
    assign bus.out_shift     = head.shift;
    assign bus.out_rs        = head.rs;
    assign bus.out_rt        = head.rt;
    assign bus.out_rd        = head.rd;
    assign bus.out_imm       = head.imm;
    assign bus.out_use_imm   = head.use_imm;
    assign bus.out_reg_write = head.reg_write;
    assign bus.out_mem_read  = head.mem_read;
    assign bus.out_mem_write = head.mem_write;
    assign bus.out_branch    = head.branch;
    assign bus.out_illegal   = head.illegal;
endmodule

// File: tb/tb_alu_op_issue.sv
// Bench for alu_op_issue: decode vector table, FIFO/flush/reset sequences,
// then random traffic against a queue-based reference model.
module tb_alu_op_issue;
    logic clk;
    logic rst;
    alu_op_issue_if bus ();

    alu_op_issue #(.DEPTH(2), .LUI_SHAMT(5'd16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  func;
        logic [4:0]  shift;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        use_imm;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        br;
        logic        ill;
    } dec_t;

    typedef struct {
        logic [31:0] instr;
        dec_t        exp;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic dec_t got();
        dec_t d;
        d.func    = bus.out_func;
        d.shift   = bus.out_shift;
        d.rs      = bus.out_rs;
        d.rt      = bus.out_rt;
        d.rd      = bus.out_rd;
        d.imm     = bus.out_imm;
        d.use_imm = bus.out_use_imm;
        d.rw      = bus.out_reg_write;
        d.mr      = bus.out_mem_read;
        d.mw      = bus.out_mem_write;
        d.br      = bus.out_branch;
        d.ill     = bus.out_illegal;
        return d;
    endfunction

    function automatic dec_t mk(int f, int sh, int rs, int rt, int rd,
                                logic [31:0] imm, int ui, int rw,
                                int mr, int mw, int br, int il);
        dec_t d;
        d.func = 2'(f); d.shift = 5'(sh);
        d.rs = 5'(rs); d.rt = 5'(rt); d.rd = 5'(rd);
        d.imm = imm; d.use_imm = 1'(ui); d.rw = 1'(rw);
        d.mr = 1'(mr); d.mw = 1'(mw); d.br = 1'(br); d.ill = 1'(il);
        return d;
    endfunction

    // reference decode straight from the opcode/funct table
    function automatic dec_t ref_dec(logic [31:0] w);
        dec_t d;
        int op;
        int fn;
        op = int'(w[31:26]);
        fn = int'(w[5:0]);
        d = '0;
        d.rs = w[25:21];
        d.rt = w[20:16];
        d.rd = (op == 0) ? w[15:11] : w[20:16];
        d.imm = {{16{w[15]}}, w[15:0]};
        d.func = 2'd1;
        case (op)
            0: case (fn)
                'h20, 'h21: d.rw = 1;
                'h22, 'h23: begin d.func = 2; d.rw = 1; end
                'h25: begin d.func = 3; d.rw = 1; end
                'h00: begin d.func = 0; d.shift = w[10:6]; d.rw = 1; end
                default: d.ill = 1;
            endcase
            'h08, 'h09: begin d.use_imm = 1; d.rw = 1; end
            'h0D: begin
                d.func = 3; d.imm = {16'h0, w[15:0]};
                d.use_imm = 1; d.rw = 1;
            end
            'h23: begin d.use_imm = 1; d.mr = 1; d.rw = 1; end
            'h2B: begin d.use_imm = 1; d.mw = 1; end
            'h04: begin d.func = 2; d.br = 1; end
            'h0F: begin
                d.func = 0; d.shift = 16; d.imm = {16'h0, w[15:0]};
                d.use_imm = 1; d.rw = 1;
            end
            default: d.ill = 1;
        endcase
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.in_instr  = 32'h0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic push(logic [31:0] w);
        bus.in_valid = 1'b1;
        bus.in_instr = w;
        tick();
        bus.in_valid = 1'b0;
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [31:0] w;
        int          ops[11];
        int          fns[7];
        ops = '{0, 0, 0, 'h08, 'h09, 'h0D, 'h23, 'h2B, 'h04, 'h0F, 99};
        fns = '{'h20, 'h21, 'h22, 'h23, 'h25, 0, 99};
        w = $urandom;
        if (ops[$urandom_range(10)] != 99)
            w[31:26] = 6'(ops[$urandom_range(9)]);
        if (w[31:26] == 6'h00 && fns[$urandom_range(6)] != 99)
            w[5:0] = 6'(fns[$urandom_range(5)]);
        return w;
    endfunction

    vec_t        tbl[13];
    logic [31:0] q[$];
    logic [31:0] w;
    logic        v;
    logic        r;
    logic        f;

    initial begin
        tbl[0]  = '{32'h012A4020, mk(1, 0, 9, 10, 8, 32'h00004020, 0, 1, 0, 0, 0, 0)};
        tbl[1]  = '{32'h3C011234, mk(0, 16, 0, 1, 1, 32'h00001234, 1, 1, 0, 0, 0, 0)};
        tbl[2]  = '{32'h8D28FFFC, mk(1, 0, 9, 8, 8, 32'hFFFFFFFC, 1, 1, 1, 0, 0, 0)};
        tbl[3]  = '{32'hFC000000, mk(1, 0, 0, 0, 0, 32'h00000000, 0, 0, 0, 0, 0, 1)};
        tbl[4]  = '{32'h00000000, mk(0, 0, 0, 0, 0, 32'h00000000, 0, 1, 0, 0, 0, 0)};
        tbl[5]  = '{32'h000A4940, mk(0, 5, 0, 10, 9, 32'h00004940, 0, 1, 0, 0, 0, 0)};
        tbl[6]  = '{32'h3508FFFF, mk(3, 0, 8, 8, 8, 32'h0000FFFF, 1, 1, 0, 0, 0, 0)};
        tbl[7]  = '{32'hAD2A0004, mk(1, 0, 9, 10, 10, 32'h00000004, 1, 0, 0, 1, 0, 0)};
        tbl[8]  = '{32'h1109FFFE, mk(2, 0, 8, 9, 9, 32'hFFFFFFFE, 0, 0, 0, 0, 1, 0)};
        tbl[9]  = '{32'h012A4022, mk(2, 0, 9, 10, 8, 32'h00004022, 0, 1, 0, 0, 0, 0)};
        tbl[10] = '{32'h012A4025, mk(3, 0, 9, 10, 8, 32'h00004025, 0, 1, 0, 0, 0, 0)};
        tbl[11] = '{32'h012A402A, mk(1, 0, 9, 10, 8, 32'h0000402A, 0, 0, 0, 0, 0, 1)};
        tbl[12] = '{32'h2128FFFF, mk(1, 0, 9, 8, 8, 32'hFFFFFFFF, 1, 1, 0, 0, 0, 0)};

        idle();
        rst = 1'b1;
        tick();
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_payload", 64'(got()), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        foreach (tbl[i]) begin
            push(tbl[i].instr);
            chk($sformatf("vec%0d_valid", i), 64'(bus.out_valid), 64'd1);
            chk($sformatf("vec%0d_dec", i), 64'(got()), 64'(tbl[i].exp));
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
            chk($sformatf("vec%0d_drain", i), 64'(bus.out_valid), 64'd0);
        end

        push(32'h012A4020);
        chk("fifo_ready1", 64'(bus.in_ready), 64'd1);
        push(32'h3C011234);
        chk("fifo_ready2", 64'(bus.in_ready), 64'd0);
        push(32'h8D28FFFC);
        chk("fifo_held_rd", 64'(bus.out_rd), 64'd8);
        chk("fifo_ready3", 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b1;
        tick();
        chk("fifo_second", 64'(got()), 64'(tbl[1].exp));
        chk("fifo_ready_back", 64'(bus.in_ready), 64'd1);
        tick();
        chk("fifo_empty", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b0;

        push(32'h012A4022);
        push(32'h012A4025);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h3C011234;
        tick();
        idle();
        chk("flush_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        tick();
        tick();
        chk("flush_no_ghost", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b0;

        push(32'h012A4020);
        push(32'h012A4022);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_ready", 64'(bus.in_ready), 64'd1);
        chk("mid_rst_func", 64'(bus.out_func), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        q.delete();
        for (int c = 0; c < 600; c++) begin
            chk("rnd_valid", 64'(bus.out_valid), 64'(q.size() > 0));
            chk("rnd_ready", 64'(bus.in_ready), 64'(q.size() < 2));
            if (q.size() > 0)
                chk("rnd_head", 64'(got()), 64'(ref_dec(q[0])));
            v = ($urandom_range(3) != 0);
            r = ($urandom_range(2) != 0);
            f = ($urandom_range(24) == 0);
            w = rnd_instr();
            bus.in_valid  = v;
            bus.in_instr  = w;
            bus.out_ready = r;
            bus.flush     = f;
            if (f) begin
                q.delete();
            end else begin
                logic can_push;
                can_push = (q.size() < 2);
                if (r && q.size() > 0) void'(q.pop_front());
                if (v && can_push) q.push_back(w);
            end
            tick();
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
